// File: rtl/windowed_bit_vote_pkg.sv
// windowed_vote_pkg: shared types and the vote rule for windowed_bit_vote.
//   win_state_t    : window occupancy state (EMPTY / FILLING / FULL)
//   MODE_MINORITY  : mode=0, dout=1 when zeros outnumber ones
//   MODE_MAJORITY  : mode=1, dout=1 when ones outnumber zeros
//   vote()         : decision for a complete window of w bits holding 'ones' ones
package windowed_vote_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } win_state_t;

  localparam logic MODE_MINORITY = 1'b0;
  localparam logic MODE_MAJORITY = 1'b1;

  // Decision for one complete window. A tie is only possible for even w.
  function automatic logic vote(input int unsigned ones, input int unsigned w,
                                input logic mode, input logic tie);
    int unsigned zeros;
    zeros = w - ones;
    if (zeros == ones) return tie;
    if (mode == MODE_MAJORITY) return (ones > zeros);
    return (zeros > ones);
  endfunction

endpackage

// File: rtl/windowed_bit_vote_if.sv
// windowed_bit_vote_if: serial bit stream in, per-window decisions out.
//   clear       : synchronous window flush (wins over din_valid)
//   din_valid   : din is accepted this cycle
//   din         : serial data bit
//   mode        : 0 = minority vote, 1 = majority vote (sampled with the bit)
//   dout_valid  : one-cycle pulse, dout/ones_count describe a complete window
//   dout        : vote result
//   ones_count  : ones in the current window contents
//   window_full : window holds W valid bits
// master = stream source, slave = detector.
interface windowed_bit_vote_if #(
  parameter int CW = 3
) ();
  logic          clear;
  logic          din_valid;
  logic          din;
  logic          mode;
  logic          dout_valid;
  logic          dout;
  logic [CW-1:0] ones_count;
  logic          window_full;

  modport master (
    output clear, din_valid, din, mode,
    input  dout_valid, dout, ones_count, window_full
  );

  modport slave (
    input  clear, din_valid, din, mode,
    output dout_valid, dout, ones_count, window_full
  );
endinterface

// File: rtl/windowed_bit_vote_shreg.sv
// bit_window_shreg: W-deep serial shift register holding the last W accepted
// bits, with an oldest-bit tap used for the incremental ones count.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, empties the register
//   en      : shift din in this cycle
//   clr     : synchronous clear (priority over en)
//   din     : bit shifted into position 0
//   oldest  : bit that leaves on the next shift (position W-1)
module bit_window_shreg #(
  parameter int W = 5
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic oldest
);

  logic [W-1:0] sr_p0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_p0 <= '0;
    end else if (clr) begin
      sr_p0 <= '0;
    end else if (en) begin
      sr_p0 <= {sr_p0[W-2:0], din};
    end
  end

  assign oldest = sr_p0[W-1];

endmodule

// File: rtl/windowed_bit_vote.sv
// windowed_bit_vote: streaming minority/majority detector over a serial bit
// stream with a W-bit window, sliding (decision per accepted bit once full)
// or tumbling (decision per W accepted bits).
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset; all outputs 0, state EMPTY
//   bus     : windowed_bit_vote_if slave (stream in, decisions out)
// Parameters: W window depth (>=2), SLIDING window style, TIE_VALUE result
// for ones == zeros, CW derived count width.
module windowed_bit_vote
  import windowed_vote_pkg::*;
#(
  parameter int W         = 5,
  parameter bit SLIDING   = 1'b1,
  parameter bit TIE_VALUE = 1'b1,
  parameter int CW        = $clog2(W + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  windowed_bit_vote_if.slave bus
);

  win_state_t    state_p0, state_nxt;
  logic [CW-1:0] fill_p0, fill_nxt;
  logic [CW-1:0] ones_p0, ones_nxt;
  logic          dout_p0, dout_nxt;
  logic          vld_p0, vld_nxt;
  logic          full_p0, full_nxt;

  logic          sr_en;
  logic          sr_clr;
  logic          oldest;

  // Effective occupancy/count the incoming bit builds on. In tumbling mode
  // the cycle after a decision starts from an empty window.
  logic [CW-1:0] base_fill;
  logic [CW-1:0] base_ones;

  bit_window_shreg #(.W(W)) u_shreg (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (sr_en),
    .clr     (sr_clr),
    .din     (bus.din),
    .oldest  (oldest)
  );

  always_comb begin
    state_nxt = state_p0;
    fill_nxt  = fill_p0;
    ones_nxt  = ones_p0;
    dout_nxt  = dout_p0;
    vld_nxt   = 1'b0;
    full_nxt  = full_p0;
    sr_en     = 1'b0;
    sr_clr    = 1'b0;
    base_fill = fill_p0;
    base_ones = ones_p0;

    if (bus.clear) begin
      // Flush; an accepted bit in the same cycle is dropped, dout holds.
      state_nxt = EMPTY;
      fill_nxt  = '0;
      ones_nxt  = '0;
      full_nxt  = 1'b0;
      sr_clr    = 1'b1;
    end else begin
      // Tumbling: the completed window is shown for exactly one cycle,
      // then the window empties whether or not a new bit arrives.
      if (!SLIDING && state_p0 == FULL) begin
        state_nxt = EMPTY;
        base_fill = '0;
        base_ones = '0;
        fill_nxt  = '0;
        ones_nxt  = '0;
        full_nxt  = 1'b0;
      end

      if (bus.din_valid) begin
        sr_en = 1'b1;
        if (SLIDING && state_p0 == FULL) begin
          // Modular arithmetic: the intermediate may wrap, the result is
          // always within 0..W.
          ones_nxt = ones_p0 + CW'(bus.din) - CW'(oldest);
          fill_nxt = CW'(W);
        end else begin
          ones_nxt = base_ones + CW'(bus.din);
          fill_nxt = base_fill + CW'(1);
        end

        full_nxt = (fill_nxt == CW'(W));

        if (fill_nxt == CW'(W)) begin
          state_nxt = FULL;
          vld_nxt   = 1'b1;
          dout_nxt  = vote(int'(ones_nxt), W, bus.mode, TIE_VALUE);
          // Tumbling windows never look at old bits; drop them with the
          // decision so the next window starts from zeros.
          if (!SLIDING) sr_clr = 1'b1;
        end else begin
          state_nxt = FILLING;
        end
      end
    end
  end

  // Stage boundary: every output and the window state register here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_p0 <= EMPTY;
      fill_p0  <= '0;
      ones_p0  <= '0;
      dout_p0  <= 1'b0;
      vld_p0   <= 1'b0;
      full_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      fill_p0  <= fill_nxt;
      ones_p0  <= ones_nxt;
      dout_p0  <= dout_nxt;
      vld_p0   <= vld_nxt;
      full_p0  <= full_nxt;
    end
  end

  assign bus.dout_valid  = vld_p0;
  assign bus.dout        = dout_p0;
  assign bus.ones_count  = ones_p0;
  assign bus.window_full = full_p0;

endmodule

// File: tb/tb_windowed_bit_vote.sv
// Bench for windowed_bit_vote: four instances driven with one shared stream
//   k=0 W=5 sliding  TIE=1 (main instance)
//   k=1 W=5 tumbling TIE=1
//   k=2 W=4 sliding  TIE=1
//   k=3 W=4 sliding  TIE=0
// A queue-style window model predicts every output of every instance.
module tb_windowed_bit_vote;
  import windowed_vote_pkg::*;

  localparam int NK = 4;

  logic clock;
  logic reset_n;

  windowed_bit_vote_if #(.CW(3)) if_s  ();
  windowed_bit_vote_if #(.CW(3)) if_t  ();
  windowed_bit_vote_if #(.CW(3)) if_e1 ();
  windowed_bit_vote_if #(.CW(3)) if_e0 ();

  windowed_bit_vote #(.W(5), .SLIDING(1'b1), .TIE_VALUE(1'b1)) dut_s (
    .clock(clock), .reset_n(reset_n), .bus(if_s));
  windowed_bit_vote #(.W(5), .SLIDING(1'b0), .TIE_VALUE(1'b1)) dut_t (
    .clock(clock), .reset_n(reset_n), .bus(if_t));
  windowed_bit_vote #(.W(4), .SLIDING(1'b1), .TIE_VALUE(1'b1)) dut_e1 (
    .clock(clock), .reset_n(reset_n), .bus(if_e1));
  windowed_bit_vote #(.W(4), .SLIDING(1'b1), .TIE_VALUE(1'b0)) dut_e0 (
    .clock(clock), .reset_n(reset_n), .bus(if_e0));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic       o_dv   [NK];
  logic       o_dout [NK];
  logic       o_wf   [NK];
  logic [2:0] o_ones [NK];

  assign o_dv[0] = if_s.dout_valid;  assign o_dout[0] = if_s.dout;
  assign o_wf[0] = if_s.window_full; assign o_ones[0] = if_s.ones_count;
  assign o_dv[1] = if_t.dout_valid;  assign o_dout[1] = if_t.dout;
  assign o_wf[1] = if_t.window_full; assign o_ones[1] = if_t.ones_count;
  assign o_dv[2] = if_e1.dout_valid;  assign o_dout[2] = if_e1.dout;
  assign o_wf[2] = if_e1.window_full; assign o_ones[2] = if_e1.ones_count;
  assign o_dv[3] = if_e0.dout_valid;  assign o_dout[3] = if_e0.dout;
  assign o_wf[3] = if_e0.window_full; assign o_ones[3] = if_e0.ones_count;

  int passed;
  int total;

  // Reference model: window contents as a plain bit list per instance.
  int kw   [NK] = '{5, 5, 4, 4};
  bit ksl  [NK] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit ktie [NK] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int win  [NK][8];
  int len  [NK];
  bit pend [NK];
  int e_ones [NK];
  bit e_dout [NK];
  bit e_dv   [NK];
  bit e_wf   [NK];

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      len[k] = 0; pend[k] = 0; e_ones[k] = 0;
      e_dout[k] = 0; e_dv[k] = 0; e_wf[k] = 0;
    end
  endtask

  task automatic model_step(input bit c, input bit v, input bit d, input bit m);
    int s;
    for (int k = 0; k < NK; k++) begin
      e_dv[k] = 0;
      if (pend[k]) begin
        len[k] = 0; e_ones[k] = 0; e_wf[k] = 0; pend[k] = 0;
      end
      if (c) begin
        len[k] = 0; e_ones[k] = 0; e_wf[k] = 0;
      end else if (v) begin
        if (ksl[k] && len[k] == kw[k]) begin
          for (int i = 0; i < len[k] - 1; i++) win[k][i] = win[k][i+1];
          len[k]--;
        end
        win[k][len[k]] = int'(d);
        len[k]++;
        s = 0;
        for (int i = 0; i < len[k]; i++) s += win[k][i];
        e_ones[k] = s;
        if (len[k] == kw[k]) begin
          e_dv[k] = 1; e_wf[k] = 1;
          e_dout[k] = vote(s, kw[k], m, ktie[k]);
          if (!ksl[k]) pend[k] = 1;
        end else begin
          e_wf[k] = 0;
        end
      end
    end
  endtask

  // Apply one cycle of stimulus to all instances, advance the model, and
  // return 1 time unit after the edge for sampling.
  task automatic drive(input bit c, input bit v, input bit d, input bit m);
    if_s.clear  = c; if_s.din_valid  = v; if_s.din  = d; if_s.mode  = m;
    if_t.clear  = c; if_t.din_valid  = v; if_t.din  = d; if_t.mode  = m;
    if_e1.clear = c; if_e1.din_valid = v; if_e1.din = d; if_e1.mode = m;
    if_e0.clear = c; if_e0.din_valid = v; if_e0.din = d; if_e0.mode = m;
    @(posedge clock);
    model_step(c, v, d, m);
    #1;
  endtask

  task automatic test_reset();
    // reset state right after power-up reset
    for (int k = 0; k < NK; k++) begin
      total++;
      if ({o_dv[k], o_dout[k], o_wf[k], o_ones[k]} !== 6'b0)
        $display("FAIL reset_init k=%0d got=%b want=000000", k,
                 {o_dv[k], o_dout[k], o_wf[k], o_ones[k]});
      else passed++;
    end
    // async reset mid-fill discards the partial window
    drive(0, 1, 1, 0); drive(0, 1, 1, 0); drive(0, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NK; k++) begin
      total++;
      if ({o_dv[k], o_dout[k], o_wf[k], o_ones[k]} !== 6'b0)
        $display("FAIL reset_async k=%0d got=%b want=000000", k,
                 {o_dv[k], o_dout[k], o_wf[k], o_ones[k]});
      else passed++;
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 1, 0);
      total++;
      if (o_dv[0] !== (i == 5))
        $display("FAIL reset_refill bit=%0d dout_valid got=%b want=%b", i, o_dv[0], (i == 5));
      else passed++;
    end
    total++;
    if (o_ones[0] !== 3'd5) $display("FAIL reset_refill_ones got=%0d want=5", o_ones[0]);
    else passed++;
  endtask

  task automatic test_sliding();
    bit bits [5] = '{1, 0, 0, 1, 0};
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, bits[i], MODE_MINORITY);
      total++;
      if (o_dv[0] !== (i == 4))
        $display("FAIL slide_fill bit=%0d dout_valid got=%b want=%b", i, o_dv[0], (i == 4));
      else passed++;
    end
    total++;
    if ({o_ones[0], o_dout[0], o_wf[0]} !== {3'd2, 1'b1, 1'b1})
      $display("FAIL slide_first ones=%0d dout=%b full=%b want ones=2 dout=1 full=1",
               o_ones[0], o_dout[0], o_wf[0]);
    else passed++;
    drive(0, 1, 1, MODE_MINORITY);
    total++;
    if ({o_dv[0], o_ones[0], o_dout[0]} !== {1'b1, 3'd2, 1'b1})
      $display("FAIL slide_6 dv=%b ones=%0d dout=%b want dv=1 ones=2 dout=1", o_dv[0], o_ones[0], o_dout[0]);
    else passed++;
    drive(0, 1, 1, MODE_MINORITY);
    total++;
    if ({o_dv[0], o_ones[0], o_dout[0]} !== {1'b1, 3'd3, 1'b0})
      $display("FAIL slide_7 dv=%b ones=%0d dout=%b want dv=1 ones=3 dout=0", o_dv[0], o_ones[0], o_dout[0]);
    else passed++;
    drive(0, 1, 1, MODE_MAJORITY);
    total++;
    if ({o_dv[0], o_ones[0], o_dout[0]} !== {1'b1, 3'd4, 1'b1})
      $display("FAIL slide_8_major dv=%b ones=%0d dout=%b want dv=1 ones=4 dout=1", o_dv[0], o_ones[0], o_dout[0]);
    else passed++;
  endtask

  task automatic test_tumbling();
    bit bits [10] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    int pulses;
    pulses = 0;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, bits[i], MODE_MINORITY);
      if (o_dv[1] === 1'b1) pulses++;
      if (i == 4) begin
        total++;
        if ({o_dv[1], o_ones[1], o_dout[1], o_wf[1]} !== {1'b1, 3'd3, 1'b0, 1'b1})
          $display("FAIL tumble_first dv=%b ones=%0d dout=%b full=%b want 1/3/0/1",
                   o_dv[1], o_ones[1], o_dout[1], o_wf[1]);
        else passed++;
      end
      if (i == 5) begin
        total++;
        if ({o_ones[1], o_wf[1]} !== {3'd0, 1'b0})
          $display("FAIL tumble_fresh ones=%0d full=%b want ones=0 full=0", o_ones[1], o_wf[1]);
        else passed++;
      end
      if (i == 9) begin
        total++;
        if ({o_dv[1], o_ones[1], o_dout[1]} !== {1'b1, 3'd1, 1'b1})
          $display("FAIL tumble_second dv=%b ones=%0d dout=%b want 1/1/1", o_dv[1], o_ones[1], o_dout[1]);
        else passed++;
      end
    end
    drive(0, 0, 0, 0);
    total++;
    if ({o_ones[1], o_wf[1], o_dv[1]} !== {3'd0, 1'b0, 1'b0})
      $display("FAIL tumble_after ones=%0d full=%b dv=%b want 0/0/0", o_ones[1], o_wf[1], o_dv[1]);
    else passed++;
    total++;
    if (pulses != 2) $display("FAIL tumble_pulses got=%0d want=2", pulses);
    else passed++;
  endtask

  task automatic test_tie();
    bit bits [4] = '{1, 1, 0, 0};
    for (int m = 0; m < 2; m++) begin
      drive(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1, bits[i], m[0]);
      total++;
      if ({o_dv[2], o_ones[2], o_dout[2]} !== {1'b1, 3'd2, 1'b1})
        $display("FAIL tie_t1 mode=%0d dv=%b ones=%0d dout=%b want 1/2/1", m, o_dv[2], o_ones[2], o_dout[2]);
      else passed++;
      total++;
      if ({o_dv[3], o_ones[3], o_dout[3]} !== {1'b1, 3'd2, 1'b0})
        $display("FAIL tie_t0 mode=%0d dv=%b ones=%0d dout=%b want 1/2/0", m, o_dv[3], o_ones[3], o_dout[3]);
      else passed++;
    end
  endtask

  task automatic test_bubbles_clear();
    bit bits [8]      = '{1, 1, 0, 1, 0, 0, 0, 1};
    bit want_dout [4] = '{0, 1, 1, 1};
    int want_ones [4] = '{3, 2, 1, 2};
    int n;
    for (int gap = 0; gap < 2; gap++) begin
      drive(1, 0, 0, 0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
        if (gap != 0) begin
          for (int b = 0; b < int'($urandom_range(1, 3)); b++)
            drive(0, 0, 1'($urandom), 1'($urandom));
          total++;
          if (o_dv[0] !== 1'b0) $display("FAIL bubble_dv gap bit=%0d got=%b want=0", i, o_dv[0]);
          else passed++;
        end
        drive(0, 1, bits[i], MODE_MINORITY);
        if (o_dv[0] === 1'b1) begin
          total++;
          if (n >= 4 || o_dout[0] !== want_dout[n] || o_ones[0] !== 3'(want_ones[n]))
            $display("FAIL bubble_dec gap=%0d n=%0d dout=%b ones=%0d", gap, n, o_dout[0], o_ones[0]);
          else passed++;
          n++;
        end
      end
      total++;
      if (n != 4) $display("FAIL bubble_count gap=%0d got=%0d want=4", gap, n);
      else passed++;
    end
    // clear together with a valid bit: the bit is dropped
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, MODE_MINORITY);
    drive(1, 1, 1, MODE_MINORITY);
    total++;
    if ({o_ones[0], o_dv[0], o_wf[0]} !== {3'd0, 1'b0, 1'b0})
      $display("FAIL clear_drop ones=%0d dv=%b full=%b want 0/0/0", o_ones[0], o_dv[0], o_wf[0]);
    else passed++;
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 1, MODE_MINORITY);
      total++;
      if (o_dv[0] !== (i == 5))
        $display("FAIL clear_refill bit=%0d dv=%b want=%b", i, o_dv[0], (i == 5));
      else passed++;
    end
    total++;
    if ({o_ones[0], o_dout[0]} !== {3'd5, 1'b0})
      $display("FAIL clear_refill_val ones=%0d dout=%b want 5/0", o_ones[0], o_dout[0]);
    else passed++;
  endtask

  task automatic test_random();
    bit c, v, d, m;
    for (int n = 0; n < 10000; n++) begin
      c = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) < 7);
      d = 1'($urandom);
      m = 1'($urandom);
      drive(c, v, d, m);
      for (int k = 0; k < NK; k++) begin
        total++;
        if (o_dv[k] !== e_dv[k] || o_dout[k] !== e_dout[k] ||
            o_ones[k] !== 3'(e_ones[k]) || o_wf[k] !== e_wf[k])
          $display("FAIL random n=%0d k=%0d got dv=%b dout=%b ones=%0d full=%b want dv=%b dout=%b ones=%0d full=%b",
                   n, k, o_dv[k], o_dout[k], o_ones[k], o_wf[k], e_dv[k], e_dout[k], e_ones[k], e_wf[k]);
        else passed++;
      end
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset_n = 1'b0;
    if_s.clear  = 0; if_s.din_valid  = 0; if_s.din  = 0; if_s.mode  = 0;
    if_t.clear  = 0; if_t.din_valid  = 0; if_t.din  = 0; if_t.mode  = 0;
    if_e1.clear = 0; if_e1.din_valid = 0; if_e1.din = 0; if_e1.mode = 0;
    if_e0.clear = 0; if_e0.din_valid = 0; if_e0.din = 0; if_e0.mode = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_sliding();
    test_tumbling();
    test_tie();
    test_bubbles_clear();
    drive(1, 0, 0, 0);
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
